// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. It uses a shift-add
//               multiplier and a restoring divider, producing one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [2:0]                    funct3,
    input  logic [DATA_WIDTH-1:0]         rs1_val,
    input  logic [DATA_WIDTH-1:0]         rs2_val,
    input  logic [$clog2(NUM_REGS)-1:0]   rd_in,
    input  logic                          flush,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_WIDTH-1:0]         result,
    output logic [$clog2(NUM_REGS)-1:0]   rd_out
);

    localparam int W       = DATA_WIDTH;
    localparam int c_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_DIV  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]                  r_state;
    logic [1:0]                  w_next;
    logic [c_CNT_W-1:0]          r_cnt;
    logic [2*W-1:0]              r_acc;
    logic [W-1:0]                r_opb;
    logic [1:0]                  r_op;
    logic                        r_neg_q;
    logic                        r_neg_r;
    logic [W-1:0]                r_result;
    logic [$clog2(NUM_REGS)-1:0] r_rd;

    logic         w_rs1_signed, w_rs2_signed, w_a_neg, w_b_neg;
    logic [W-1:0] w_a_mag, w_b_mag;
    logic         w_div_zero, w_div_ovf, w_fast;
    logic [W-1:0] w_fast_result;
    logic [W:0]   w_mul_sum, w_shl, w_trial;
    logic [2*W-1:0] w_acc_next, w_prod;
    logic [W-1:0] w_quo, w_rem, w_final;

    // Operand conditioning: signed operands become magnitudes plus sign flags.
    always_comb begin
        w_rs1_signed  = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
        w_rs2_signed  = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
        w_a_neg       = w_rs1_signed && rs1_val[W-1];
        w_b_neg       = w_rs2_signed && rs2_val[W-1];
        w_a_mag       = w_a_neg ? -rs1_val : rs1_val;
        w_b_mag       = w_b_neg ? -rs2_val : rs2_val;
        w_div_zero    = funct3[2] && (rs2_val == '0);
        w_div_ovf     = funct3[2] && !funct3[0] && (rs1_val == {1'b1, {(W-1){1'b0}}})
                        && (rs2_val == '1);
        w_fast        = w_div_zero || w_div_ovf;
        if (w_div_zero)
            w_fast_result = funct3[1] ? rs1_val : '1;
        else
            w_fast_result = funct3[1] ? '0 : rs1_val;
    end

    // One iteration step; the final result is taken from the post-step value.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opb} : '0);
        w_shl      = r_acc[2*W-1:W-1];
        w_trial    = w_shl - {1'b0, r_opb};
        w_acc_next = r_acc;
        if (r_state == c_MUL)
            w_acc_next = {w_mul_sum, r_acc[W-1:1]};
        else if (r_state == c_DIV)
            w_acc_next = w_trial[W] ? {r_acc[2*W-2:0], 1'b0}
                                    : {w_trial[W-1:0], r_acc[W-2:0], 1'b1};
        w_prod = r_neg_q ? -w_acc_next : w_acc_next;
        w_quo  = r_neg_q ? -w_acc_next[W-1:0] : w_acc_next[W-1:0];
        w_rem  = r_neg_r ? -w_acc_next[2*W-1:W] : w_acc_next[2*W-1:W];
        if (r_state == c_DIV)
            w_final = r_op[1] ? w_rem : w_quo;
        else
            w_final = (r_op == 2'b00) ? w_prod[W-1:0] : w_prod[2*W-1:W];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (start) w_next = w_fast ? c_DONE : (funct3[2] ? c_DIV : c_MUL);
            c_MUL,
            c_DIV:  if (r_cnt == c_LAST) w_next = c_DONE;
            c_DONE: w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
        if (flush)
            w_next = c_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= c_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_rd     <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_op    <= funct3[1:0];
                        r_rd    <= rd_in;
                        r_cnt   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_opb   <= funct3[2] ? w_b_mag : w_a_mag;
                        r_acc   <= {{W{1'b0}}, (funct3[2] ? w_a_mag : w_b_mag)};
                        if (w_fast)
                            r_result <= w_fast_result;
                    end
                end
                c_MUL, c_DIV: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST)
                        r_result <= w_final;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != c_IDLE);
    assign done   = (r_state == c_DONE);
    assign result = r_result;
    assign rd_out = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Randomized self-checking bench for muldiv_unit against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n, start, flush, busy, done;
    logic [2:0]    funct3;
    logic [W-1:0]  rs1_val, rs2_val, result;
    logic [4:0]    rd_in, rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.DATA_WIDTH(W), .NUM_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_in(rd_in), .flush(flush),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa, sb, sub;
        logic [63:0]        ua, ub, p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        sub = $signed(ub);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'b000: begin p = ua * ub;   return p[31:0];  end
            3'b001: begin p = sa * sb;   return p[63:32]; end
            3'b010: begin p = sa * sub;  return p[63:32]; end
            3'b011: begin p = ua * ub;   return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return 32'($signed(a) / $signed(b));
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Runs one operation; with hold set, start stays high with new operands.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold);
        logic [31:0] exp;
        bit          fast;
        int          lat, busy_bad;
        exp  = ref_model(f, a, b);
        fast = f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd;
        @(posedge clk); #1;
        if (hold) begin
            rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
        end else begin
            start = 1'b0;
        end
        lat = 1; busy_bad = 0;
        while (!done && lat < 100) begin
            if (!busy) busy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("latency", 64'(lat), fast ? 64'd1 : 64'(W + 1));
        check("result", 64'(result), 64'(exp));
        check("rd_out", 64'(rd_out), 64'(rd));
        check("busy_in_op", 64'(busy_bad), 64'd0);
        check("busy_done", 64'(busy), 64'd1);
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0;
        rs1_val = '0; rs2_val = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        @(negedge clk) rst_n = 1'b1;

        do_op(3'b000, 32'h7,         32'hFFFF_FFFD, 5'd10, 1'b0);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1,  1'b0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  1'b0);
        do_op(3'b010, 32'hFFFF_FFFF, 32'h2,         5'd3,  1'b0);
        do_op(3'b100, 32'hFFFF_FFF9, 32'h2,         5'd4,  1'b0);
        do_op(3'b110, 32'hFFFF_FFF9, 32'h2,         5'd5,  1'b0);
        do_op(3'b101, 32'd100,       32'd7,         5'd6,  1'b0);
        do_op(3'b111, 32'd100,       32'd7,         5'd7,  1'b0);
        do_op(3'b100, 32'd5,         32'd0,         5'd8,  1'b0);
        do_op(3'b111, 32'd5,         32'd0,         5'd9,  1'b0);
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 1'b0);
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  1'b0);
        do_op(3'b000, 32'h1234_5678, 32'h9ABC_DEF1, 5'd12, 1'b1);
        do_op(3'b101, 32'hDEAD_BEEF, 32'h1234,      5'd13, 1'b1);

        // Flush a divide in its tenth busy cycle.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; rs1_val = 32'd1000; rs2_val = 32'd7; rd_in = 5'd14;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (done) dones++; end
        check("flush_no_done", 64'(dones), 64'd0);
        do_op(3'b100, 32'd1000, 32'd7, 5'd15, 1'b0);

        for (int i = 0; i < 150; i++)
            do_op(3'($urandom), rnd_operand(), rnd_operand(), 5'($urandom), 1'b0);

        // Asynchronous reset in the middle of a multiply.
        do_op(3'b000, 32'd3, 32'd5, 5'd16, 1'b0);
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd17;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", 64'(result), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (done) dones++; end
        check("arst_no_done", 64'(dones), 64'd0);
        do_op(3'b011, 32'hFFFF_0000, 32'h0001_0000, 5'd18, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
